mont_mul_seq: RTL and testbench

- Iterative radix-2 Montgomery multiplier. Computes A*B*2^-K mod N, one operand bit per clock. Parametrised operand width.
- Successor to the single-cycle combinational Montgomery product. No precomputed n_inv needed, no full-width multipliers, registered result with a start/done handshake.
- Sits under the RSA modular-exponentiation controller, which issues one multiply at a time and keeps operands in Montgomery form.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/mont_step.sv | 22 ++
 rtl/mont_mul_seq.sv | 121 ++++++++++++
 tb/tb_mont_mul_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA modular-arithmetic blocks.
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Counter must be able to hold the value K after the last iteration.
    function automatic int cnt_width(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: S' = (S + a_bit*B [+ N]) / 2.
module mont_step #(
    parameter int K = 8
) (
    input  logic [K:0]   s,
    input  logic         a_bit,
    input  logic [K-1:0] b,
    input  logic [K-1:0] n,
    output logic [K:0]   s_next
);

    logic [K+1:0] t_add;
    logic [K+1:0] t_odd;

    // S < 2N keeps S + B + N below 4N, so K+2 bits never overflow.
    always_comb begin
        t_add  = {1'b0, s} + (a_bit ? {2'b00, b} : '0);
        t_odd  = t_add[0] ? (t_add + {2'b00, n}) : t_add;
        s_next = (K+1)'(t_odd >> 1);
    end

endmodule

// File: rtl/mont_mul_seq.sv
// Iterative radix-2 Montgomery multiplier: result = A*B*2^-K mod N, one bit of A per clock.
module mont_mul_seq
    import rsa_pkg::*;
#(
    parameter int K  = 8,
    parameter int CW = cnt_width(K)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic [K-1:0] n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [K-1:0] result
);

    state_e        state_q, state_d;
    logic [K-1:0]  a_q, a_d;
    logic [K-1:0]  b_q, b_d;
    logic [K-1:0]  n_q, n_d;
    logic [K:0]    s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [K-1:0]  result_q, result_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [K:0]    s_next;
    logic [K-1:0]  s_red;

    // a_q is shifted right each iteration so bit 0 is always the current operand bit.
    mont_step #(.K(K)) u_step (
        .s      (s_q),
        .a_bit  (a_q[0]),
        .b      (b_q),
        .n      (n_q),
        .s_next (s_next)
    );

    // When S >= N the difference is below N, so the low K bits are exact.
    assign s_red = s_q[K-1:0] - n_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    n_d   = n;
                    s_d   = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (n[0]) begin
                        state_d = RUN;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                s_d   = s_next;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = (s_q >= {1'b0, n_q}) ? s_red : s_q[K-1:0];
                done_d   = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_mont_mul_seq.sv
// Directed and reference-model checks for mont_mul_seq at K=8 and K=16.
module tb_mont_mul_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic [7:0]  a8, b8, n8, result8;
    logic        busy8, done8, err8;

    logic        start16;
    logic [15:0] a16, b16, n16, result16;
    logic        busy16, done16, err16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mont_mul_seq #(.K(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .n      (n8),
        .busy   (busy8),
        .done   (done8),
        .err    (err8),
        .result (result8)
    );

    mont_mul_seq #(.K(16)) dut16 (
        .clk    (clk),
        .rst    (rst),
        .start  (start16),
        .a      (a16),
        .b      (b16),
        .n      (n16),
        .busy   (busy16),
        .done   (done16),
        .err    (err16),
        .result (result16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one K=8 operation and wait (bounded) for done.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                       output logic [7:0] res, output logic er, output logic er0,
                       output int busy_cnt, output int lat);
        a8 = a;
        b8 = b;
        n8 = n;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        er0 = err8;
        busy_cnt = 0;
        lat = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            tick();
            lat++;
        end
        res = result8;
        er  = err8;
    endtask

    logic [7:0]  res;
    logic        er, er0, seen;
    int          bc, lat;
    longint      rinv;
    int unsigned av, bv;
    logic [31:0] exp32;

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; n8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0; n16 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",   32'(busy8),   32'd0);
        check("rst_done",   32'(done8),   32'd0);
        check("rst_err",    32'(err8),    32'd0);
        check("rst_result", 32'(result8), 32'd0);

        // 5*7*2^-8 mod 13 = 1
        op8(8'd5, 8'd7, 8'd13, res, er, er0, bc, lat);
        check("basic_res",  32'(res), 32'd1);
        check("basic_err",  32'(er),  32'd0);
        check("basic_busy", 32'(bc),  32'd9);
        check("basic_lat",  32'(lat), 32'd9);
        tick();
        check("done_pulse",  32'(done8),   32'd0);
        check("result_hold", 32'(result8), 32'd1);

        // 254*254*2^-8 mod 255 = 1 (2^8 = 1 mod 255)
        op8(8'd254, 8'd254, 8'd255, res, er, er0, bc, lat);
        check("n255_res", 32'(res), 32'd1);
        check("n255_lat", 32'(lat), 32'd9);

        // Zero operand, then back-to-back start issued in the done cycle
        op8(8'd0, 8'd12, 8'd13, res, er, er0, bc, lat);
        check("zero_res", 32'(res), 32'd0);
        op8(8'd1, 8'd1, 8'd13, res, er, er0, bc, lat);
        check("b2b_res",  32'(res), 32'd3);
        check("b2b_busy", 32'(bc),  32'd9);
        check("b2b_lat",  32'(lat), 32'd9);

        // Even modulus: immediate done with err
        tick();
        op8(8'd3, 8'd4, 8'd12, res, er, er0, bc, lat);
        check("even_res",  32'(res), 32'd0);
        check("even_err",  32'(er),  32'd1);
        check("even_lat",  32'(lat), 32'd0);
        check("even_busy", 32'(bc),  32'd0);
        tick();
        check("even_err_hold", 32'(err8), 32'd1);
        op8(8'd5, 8'd7, 8'd13, res, er, er0, bc, lat);
        check("err_clear_on_start", 32'(er0), 32'd0);
        check("after_even_res",     32'(res), 32'd1);
        check("after_even_err",     32'(er),  32'd0);

        // Reset at RUN counter=4, with start asserted in the reset cycle
        tick();
        a8 = 8'd5; b8 = 8'd7; n8 = 8'd13; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        start8 = 1'b1;
        tick();
        rst = 1'b0;
        start8 = 1'b0;
        check("abort_busy",   32'(busy8),   32'd0);
        check("abort_done",   32'(done8),   32'd0);
        check("abort_result", 32'(result8), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (done8 || busy8) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // Inputs changed mid-RUN (and a start while busy) must not disturb the operation
        a8 = 8'd5; b8 = 8'd7; n8 = 8'd13; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        a8 = 8'hff; b8 = 8'h0c; n8 = 8'h07; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 4;
        while (!done8 && lat < 40) begin
            tick();
            lat++;
        end
        check("midrun_res", 32'(result8), 32'd1);
        check("midrun_lat", 32'(lat),     32'd9);

        // K=16, N=65521: reference via inverse of 2^16 mod N
        rinv = 0;
        for (longint x = 1; x < 65521; x++) begin
            if (((longint'(65536) * x) % 65521) == 1) begin
                rinv = x;
                break;
            end
        end
        n16 = 16'd65521;
        for (int i = 0; i < 200; i++) begin
            av = (i == 0) ? 32'd65520 : $urandom_range(0, 65520);
            bv = (i == 0) ? 32'd65520 : $urandom_range(0, 65520);
            exp32 = 32'((((longint'(av) * longint'(bv)) % 65521) * rinv) % 65521);
            a16 = 16'(av);
            b16 = 16'(bv);
            start16 = 1'b1;
            tick();
            start16 = 1'b0;
            lat = 0;
            while (!done16 && lat < 60) begin
                tick();
                lat++;
            end
            check("k16_res", 32'(result16), exp32);
            check("k16_lat", 32'(lat),      32'd17);
        end
        tick();
        check("k16_err_end",  32'(err16),  32'd0);
        check("k16_busy_end", 32'(busy16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
